rf_access_ctrl: RTL and testbench

- Requester-side controller for the 16-entry register file (RF): 2 asynchronous read ports and 1 clocked write port.
- Accepts decoded instructions from issue and drives the RF read addresses.
- Captures operands into a one-entry output register with a valid/ready handshake to execute.
- Forwards writeback results into the RF write port, and keeps a pending-write scoreboard that stalls RAW/WAW hazards.

---
 rtl/rf_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_rf_access_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: issue-side register file read, operand capture and pending-write scoreboard.
// Optional build macro WB_BYPASS_EN forwards same-cycle writeback data to issuing sources.
module rf_access_ctrl #(
    parameter int NUM_REGS = 16,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [4:0]       iss_rs1,
    input  logic [4:0]       iss_rs2,
    input  logic [4:0]       iss_rd,
    input  logic             iss_wen,
    input  logic [TAG_W-1:0] iss_tag,

    output logic [4:0]       rf_ra,
    output logic [4:0]       rf_rb,
    input  logic [31:0]      rf_bus_a,
    input  logic [31:0]      rf_bus_b,
    output logic             rf_reg_write,
    output logic [4:0]       rf_rw,
    output logic [31:0]      rf_bus_w,

    output logic             op_valid,
    input  logic             op_ready,
    output logic [31:0]      op_a,
    output logic [31:0]      op_b,
    output logic [4:0]       op_rd,
    output logic             op_wen,
    output logic [TAG_W-1:0] op_tag,

    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_data,
    output logic             wb_err,
    output logic [4:0]       pend_cnt
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic                wb_hit;
    logic                byp_a, byp_b, byp_d;
    logic                haz;
    logic                issue_fire;
    logic                err_set;
    logic [31:0]         cap_a, cap_b;

    function automatic logic idx_valid(input logic [4:0] idx);
        return (idx != 5'd0) && (int'(idx) < NUM_REGS);
    endfunction

    function automatic logic is_pending(input logic [NUM_REGS-1:0] vec, input logic [4:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (idx == 5'(i)) r = vec[i];
        end
        return r;
    endfunction

    function automatic logic [4:0] popcount(input logic [NUM_REGS-1:0] vec);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + {4'd0, vec[i]};
        end
        return c;
    endfunction

    assign rf_ra        = iss_rs1;
    assign rf_rb        = iss_rs2;
    assign wb_hit       = wb_valid && idx_valid(wb_rd);
    assign rf_reg_write = wb_hit;
    assign rf_rw        = wb_rd;
    assign rf_bus_w     = wb_data;

`ifdef WB_BYPASS_EN
    // A source or destination being written back this cycle is resolved by forwarding.
    assign byp_a = wb_hit && (wb_rd == iss_rs1);
    assign byp_b = wb_hit && (wb_rd == iss_rs2);
    assign byp_d = wb_hit && (wb_rd == iss_rd);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
    assign byp_d = 1'b0;
`endif

    assign haz = (idx_valid(iss_rs1) && is_pending(pending, iss_rs1) && !byp_a) ||
                 (idx_valid(iss_rs2) && is_pending(pending, iss_rs2) && !byp_b) ||
                 (iss_wen && idx_valid(iss_rd) && is_pending(pending, iss_rd) && !byp_d);

    assign iss_ready  = !haz && (!op_valid || op_ready);
    assign issue_fire = iss_valid && iss_ready;

    assign cap_a = !idx_valid(iss_rs1) ? 32'd0 : (byp_a ? wb_data : rf_bus_a);
    assign cap_b = !idx_valid(iss_rs2) ? 32'd0 : (byp_b ? wb_data : rf_bus_b);

    assign err_set = wb_valid && ((wb_hit && !is_pending(pending, wb_rd)) ||
                                  (!idx_valid(wb_rd) && (wb_rd != 5'd0)));

    // Clear from writeback first so a same-register issue set overrides it.
    always_comb begin
        pending_nxt = pending;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wb_hit && (wb_rd == 5'(i))) pending_nxt[i] = 1'b0;
            if (issue_fire && iss_wen && (iss_rd == 5'(i))) pending_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            pend_cnt <= 5'd0;
            wb_err   <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            pend_cnt <= popcount(pending_nxt);
            if (err_set) wb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_a     <= 32'd0;
            op_b     <= 32'd0;
            op_rd    <= 5'd0;
            op_wen   <= 1'b0;
            op_tag   <= '0;
        end else if (issue_fire) begin
            op_valid <= 1'b1;
            op_a     <= cap_a;
            op_b     <= cap_b;
            op_rd    <= iss_rd;
            op_wen   <= iss_wen;
            op_tag   <= iss_tag;
        end else if (op_ready) begin
            op_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Self-checking bench for rf_access_ctrl (default build): reference scoreboard of pending
// registers and an operand queue filled at issue time and drained when execute accepts.
module tb_rf_access_ctrl;
    localparam int NUM_REGS = 16;
    localparam int TAG_W    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             iss_valid, iss_ready;
    logic [4:0]       iss_rs1, iss_rs2, iss_rd;
    logic             iss_wen;
    logic [TAG_W-1:0] iss_tag;
    logic [4:0]       rf_ra, rf_rb, rf_rw;
    logic [31:0]      rf_bus_a, rf_bus_b, rf_bus_w;
    logic             rf_reg_write;
    logic             op_valid, op_ready, op_wen;
    logic [31:0]      op_a, op_b;
    logic [4:0]       op_rd;
    logic [TAG_W-1:0] op_tag;
    logic             wb_valid, wb_err;
    logic [4:0]       wb_rd, pend_cnt;
    logic [31:0]      wb_data;

    always #5 clk = ~clk;

    rf_access_ctrl #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .iss_wen(iss_wen), .iss_tag(iss_tag),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_bus_a(rf_bus_a), .rf_bus_b(rf_bus_b),
        .rf_reg_write(rf_reg_write), .rf_rw(rf_rw), .rf_bus_w(rf_bus_w),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_rd(op_rd), .op_wen(op_wen), .op_tag(op_tag),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err),
        .pend_cnt(pend_cnt)
    );

    // Register file behind the DUT: preset contents until a location is written.
    logic [31:0] rf_mem [32];
    logic [31:0] rf_wr = '0;

    function automatic logic [31:0] init_val(input logic [4:0] i);
        if (i == 5'd3) return 32'h11;
        if (i == 5'd4) return 32'h22;
        return 32'hA000_0000 | {27'd0, i};
    endfunction

    assign rf_bus_a = rf_wr[rf_ra] ? rf_mem[rf_ra] : init_val(rf_ra);
    assign rf_bus_b = rf_wr[rf_rb] ? rf_mem[rf_rb] : init_val(rf_rb);

    always @(posedge clk) begin
        if (rf_reg_write) begin
            rf_mem[rf_rw] <= rf_bus_w;
            rf_wr[rf_rw]  <= 1'b1;
        end
    end

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [4:0]       rd;
        logic             wen;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rf_model [32];
    logic [31:0] m_pend;
    logic        m_opv, m_err;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic vld(input logic [4:0] i);
        return (i != 5'd0) && (int'(i) < NUM_REGS);
    endfunction

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wen, input logic [TAG_W-1:0] tag);
        iss_valid = 1'b1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_wen = wen; iss_tag = tag;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v; wb_rd = rd; wb_data = d;
    endtask

    // One clock: check combinational and queued outputs, advance the reference, check registered state.
    task automatic step();
        logic haz, rdy, acc, fire, wbhit;
        exp_t e;
        #1;
        haz = (vld(iss_rs1) && m_pend[iss_rs1]) || (vld(iss_rs2) && m_pend[iss_rs2]) ||
              (iss_wen && vld(iss_rd) && m_pend[iss_rd]);
        rdy = !haz && (!m_opv || op_ready);
        chk("iss_ready", {31'd0, iss_ready}, {31'd0, rdy});
        chk("rf_ra", {27'd0, rf_ra}, {27'd0, iss_rs1});
        chk("rf_rb", {27'd0, rf_rb}, {27'd0, iss_rs2});
        wbhit = wb_valid && vld(wb_rd);
        chk("rf_reg_write", {31'd0, rf_reg_write}, {31'd0, wbhit});
        if (wb_valid) begin
            chk("rf_rw", {27'd0, rf_rw}, {27'd0, wb_rd});
            chk("rf_bus_w", rf_bus_w, wb_data);
        end
        chk("op_valid", {31'd0, op_valid}, {31'd0, m_opv});
        if (m_opv && sb.size() > 0) begin
            e = sb[0];
            chk("op_a", op_a, e.a);
            chk("op_b", op_b, e.b);
            chk("op_rd", {27'd0, op_rd}, {27'd0, e.rd});
            chk("op_wen", {31'd0, op_wen}, {31'd0, e.wen});
            chk("op_tag", {28'd0, op_tag}, {28'd0, e.tag});
        end
        acc  = iss_valid && rdy;
        fire = m_opv && op_ready;
        if (fire && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin
            e.a   = vld(iss_rs1) ? rf_model[iss_rs1] : 32'd0;
            e.b   = vld(iss_rs2) ? rf_model[iss_rs2] : 32'd0;
            e.rd  = iss_rd;
            e.wen = iss_wen;
            e.tag = iss_tag;
            sb.push_back(e);
        end
        if (wb_valid && ((wbhit && !m_pend[wb_rd]) || (!vld(wb_rd) && wb_rd != 5'd0))) m_err = 1'b1;
        if (wbhit) begin
            m_pend[wb_rd]   = 1'b0;
            rf_model[wb_rd] = wb_data;
        end
        if (acc && iss_wen && vld(iss_rd)) m_pend[iss_rd] = 1'b1;
        if (acc) m_opv = 1'b1;
        else if (fire) m_opv = 1'b0;
        @(posedge clk);
        #1;
        chk("pend_cnt", {27'd0, pend_cnt}, 32'($countones(m_pend)));
        chk("wb_err", {31'd0, wb_err}, {31'd0, m_err});
    endtask

    initial begin
        logic [4:0] r;
        rst_n = 1'b0;
        iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_wen = 1'b0; iss_tag = '0;
        op_ready = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) rf_model[i] = init_val(5'(i));
        m_pend = '0; m_opv = 1'b0; m_err = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_b", op_b, 32'd0);
        chk("rst_op_rd", {27'd0, op_rd}, 32'd0);
        chk("rst_op_wen", {31'd0, op_wen}, 32'd0);
        chk("rst_op_tag", {28'd0, op_tag}, 32'd0);
        chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
        chk("rst_pend_cnt", {27'd0, pend_cnt}, 32'd0);
        rst_n = 1'b1;
        op_ready = 1'b1;

        // Basic issue, then RAW stall resolved by writeback.
        issue(5'd3, 5'd4, 5'd5, 1'b1, 4'd1); step();
        issue(5'd5, 5'd4, 5'd6, 1'b1, 4'd2); step();
        wb(1'b1, 5'd5, 32'hABCD); step();
        wb(1'b0, 5'd0, 32'd0); step();

        // Backpressure, then back-to-back throughput.
        issue(5'd1, 5'd2, 5'd0, 1'b0, 4'd3); step();
        op_ready = 1'b0;
        issue(5'd8, 5'd9, 5'd10, 1'b1, 4'd4);
        repeat (3) step();
        op_ready = 1'b1; step();
        issue(5'd1, 5'd2, 5'd11, 1'b1, 4'd5); step();
        issue(5'd12, 5'd13, 5'd0, 1'b0, 4'd6); step();

        // Invalid indexes read as zero and never become pending.
        issue(5'd0, 5'd20, 5'd0, 1'b1, 4'd7); step();
        issue(5'd20, 5'd15, 5'd20, 1'b1, 4'd8); step();
        iss_valid = 1'b0; step();

        // Writeback error cases.
        wb(1'b1, 5'd7, 32'h77); step();
        wb(1'b1, 5'd0, 32'h55); step();
        wb(1'b0, 5'd0, 32'd0); step();
        wb(1'b1, 5'd20, 32'h66); step();
        wb(1'b0, 5'd0, 32'd0); step();

        // Asynchronous reset with pending registers and a held bundle.
        op_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd0, 1'b0, 4'd9); step();
        iss_valid = 1'b0;
        chk("pre_rst_pend", {27'd0, pend_cnt}, 32'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("async_op_valid", {31'd0, op_valid}, 32'd0);
        chk("async_pend_cnt", {27'd0, pend_cnt}, 32'd0);
        chk("async_wb_err", {31'd0, wb_err}, 32'd0);
        m_pend = '0; m_opv = 1'b0; m_err = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        op_ready = 1'b1;
        wb(1'b1, 5'd6, 32'h6666); step();
        wb(1'b0, 5'd0, 32'd0); step();

        // Random traffic; writebacks mostly target pending registers.
        for (int n = 0; n < 120; n++) begin
            op_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0)
                issue(5'($urandom_range(0, 17)), 5'($urandom_range(0, 17)),
                      5'($urandom_range(0, 17)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            else
                iss_valid = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                r = 5'($urandom_range(1, 15));
                for (int k = 0; k < 16; k++) begin
                    if (m_pend[5'((int'(r) + k) % 16)]) begin
                        r = 5'((int'(r) + k) % 16);
                        break;
                    end
                end
                wb(1'b1, r, $urandom);
            end else begin
                wb(1'b0, 5'd0, 32'd0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
